// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake plus the decode/execute hand-off.
// The fetch unit is the master; memory and execute logic sit on the slave side.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic [31:0]     inst;
    logic            inst_valid;
    logic            inst_ack;
    logic            is_jal;
    logic            is_jalr;
    logic            branch_taken;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic            halt_req;
    logic [XLEN-1:0] current_pc;
    logic [XLEN-1:0] pc_plus4;
    logic            is_halted;

    modport master (
        output imem_req, imem_addr, inst, inst_valid, current_pc, pc_plus4, is_halted,
        input  imem_ready, imem_rdata, inst_ack, is_jal, is_jalr, branch_taken,
               imm, rs1_data, halt_req
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_valid, current_pc, pc_plus4, is_halted,
        output imem_ready, imem_rdata, inst_ack, is_jal, is_jalr, branch_taken,
               imm, rs1_data, halt_req
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, fetches over a stallable req/ready
// handshake, holds the word for execute, and steers the PC on acknowledge.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic       clk,
    input  logic       reset,
    fetch_unit_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        ISSUE,
        HALTED
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic [31:0]     inst;
    logic            req_q;
    logic            valid_q;
    logic            halted_q;

    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        // NOTE: default assigned first so every path drives next_pc and no latch is inferred.
        next_pc = pc_plus4;
        if (bus.is_jalr) begin
            next_pc = (bus.rs1_data + bus.imm) & ~XLEN'(1);
        end else if (bus.is_jal || bus.branch_taken) begin
            next_pc = pc + bus.imm;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= REQ;
            pc       <= RESET_PC;
            inst     <= NOP;
            req_q    <= 1'b1;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (bus.imem_ready) begin
                        inst    <= bus.imem_rdata;
                        state   <= ISSUE;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.inst_ack) begin
                        valid_q <= 1'b0;
                        // A halting ECALL freezes pc so current_pc still names it.
                        if (bus.halt_req) begin
                            state    <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            pc    <= next_pc;
                            state <= REQ;
                            req_q <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state   <= REQ;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = pc;
    assign bus.inst       = inst;
    assign bus.inst_valid = valid_q;
    assign bus.current_pc = pc;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.is_halted  = halted_q;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the opcode decoder in the RV32I core.
- Holds the architectural PC and requests instructions from an instruction memory over a req/ready handshake that may stall for several cycles.
- Latches the returned word and presents it, with valid, to the decode/execute logic.
- On execute's acknowledge, selects the next PC from the jump/branch outcome, or parks in a sticky halt state when a halt is requested.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  XLEN  fetch address; always equals current_pc.
- imem_ready  input  1  memory has imem_rdata valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- inst  output  32  latched instruction; its bits [6:0] drive the decoder opcode.
- inst_valid  output  1  inst is valid and awaiting execution.
- inst_ack  input  1  execute completed the current instruction this cycle.
- is_jal  input  1  current instruction is JAL.
- is_jalr  input  1  current instruction is JALR.
- branch_taken  input  1  conditional branch resolved taken.
- imm  input  XLEN  sign-extended immediate of the current instruction.
- rs1_data  input  XLEN  rs1 operand, used for JALR.
- halt_req  input  1  current instruction is a terminating ECALL.
- current_pc  output  XLEN  PC of the instruction in inst.
- pc_plus4  output  XLEN  current_pc+4, used as the JAL/JALR link value.
- is_halted  output  1  core has stopped fetching.

Behaviour:
- FSM states: REQ, ISSUE, HALTED.
- Reset (asynchronous, takes effect immediately, may occur in any state or mid-handshake):
  - state=REQ, pc=RESET_PC.
  - inst=32'h0000_0013 (NOP), inst_valid=0, is_halted=0.
  - A pending memory request is abandoned; an imem_ready arriving in the same cycle as reset is ignored.
- REQ:
  - imem_req=1, imem_addr=pc, both held stable until imem_ready.
  - Cycle with imem_ready=1: inst<=imem_rdata, next state ISSUE.
  - imem_ready=0: remain in REQ with no limit on stall length.
- ISSUE:
  - imem_req=0, inst_valid=1; inst and current_pc held constant.
  - inst_ack=0: remain in ISSUE.
  - inst_ack=1 and halt_req=1: next state HALTED; pc is not updated.
  - inst_ack=1 and halt_req=0: pc<=next_pc, next state REQ.
- next_pc, in fixed priority when several selects are high:
  - is_jalr: (rs1_data+imm) & ~32'h1.
  - else is_jal or branch_taken: pc+imm.
  - else pc+4.
- Arithmetic: all sums are XLEN-bit, modulo 2^XLEN; no overflow detection (0xFFFF_FFFC+4 wraps to 0x0).
- Alignment: bit 1 of a target is not checked; a misaligned target is fetched as-is.
- HALTED:
  - Sticky until reset. imem_req=0, inst_valid=0, is_halted=1.
  - All inputs are ignored.
  - current_pc keeps the address of the halting ECALL.
- Ignored inputs by state: inst_ack, halt_req and the jump/branch selects are ignored outside ISSUE. imem_ready is ignored outside REQ.
- Timing: outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- Latency: minimum 2 cycles per instruction (ready in the REQ cycle, ack in the ISSUE cycle). Each memory stall cycle or execute stall cycle adds one.

Test Plan:
- Reset, then memory ready every cycle, acks every ISSUE, no jumps -> imem_addr sequence 0x0,0x4,0x8; inst_valid toggles 0,1,0,1; 2 cycles per instruction.
- imem_ready held low 5 cycles at pc=0x8 -> imem_req=1 and imem_addr=0x8 stable throughout; inst updates only on the ready cycle.
- At pc=0x10: is_jal=1, imm=0xFFFF_FFF0 -> next fetch 0x0. Then is_jalr=1 with is_jal=1, rs1_data=0x101, imm=0x4 -> next fetch 0x104 (jalr priority, bit0 cleared).
- At pc=0x20: branch_taken=1, imm=0x40 -> next fetch 0x60. Same pc with branch_taken=0 -> next fetch 0x24. pc=0xFFFF_FFFC with no jump -> next fetch 0x0.
- halt_req=1 with inst_ack=1 at pc=0x30 -> is_halted=1 next cycle; imem_req stays 0 for 20 cycles; current_pc=0x30.
- reset asserted mid-REQ at pc=0x44 while imem_ready=1 -> inst stays 0x0000_0013, inst_valid=0; after release, first imem_addr=RESET_PC.
